// File: rtl/census_pkg.sv
// Shared constants and elaboration-time helpers for the census window stream.
package census_pkg;

   localparam int ROW_W = 16;

   function automatic int calc_r(input int win);
      return win / 2;
   endfunction

   function automatic int calc_census_w(input int win);
      return win * win - 1;
   endfunction

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

   function automatic bit win_legal(input int win);
      return (win >= 3) && (win <= 7) && ((win % 2) == 1);
   endfunction

endpackage

// File: rtl/census_line_buffer.sv
// One raster line of pixel storage: combinational read of the old entry, write at the clock edge.
module census_line_buffer
   import census_pkg::*;
#(
   parameter int PIX_W = 11,
   parameter int IMG_W = 640,
   localparam int AW = clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem_r [IMG_W];

   assign rdata = mem_r[addr];

   // Storage is deliberately unreset; stale rows are masked by the row gating upstream.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

endmodule

// File: rtl/census_window_stream.sv
// Streaming WINxWIN census transform with line buffers, frame tracking and valid signalling.
// Define CENSUS_OUT_REG_EN to add a register stage after the comparator tree (latency 3 instead of 2).
module census_window_stream
   import census_pkg::*;
#(
   parameter int PIX_W = 11,
   parameter int WIN   = 3,
   parameter int IMG_W = 640,
   localparam int R        = calc_r(WIN),
   localparam int CENSUS_W = calc_census_w(WIN),
   localparam int XW       = clog2(IMG_W)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [PIX_W-1:0]    in_pixel,
   output logic                out_valid,
   output logic [CENSUS_W-1:0] out_census,
   output logic [XW-1:0]       out_col,
   output logic [ROW_W-1:0]    out_row
);

   localparam int CENTRE = R * WIN + R;

   localparam logic [XW-1:0]    X_ZERO = {XW{1'b0}};
   localparam logic [XW-1:0]    X_ONE  = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [XW-1:0]    X_LAST = XW'(IMG_W - 1);
   localparam logic [XW-1:0]    X_MIN  = XW'(2 * R);
   localparam logic [XW-1:0]    X_OFF  = XW'(R);
   localparam logic [ROW_W-1:0] Y_ZERO = {ROW_W{1'b0}};
   localparam logic [ROW_W-1:0] Y_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
   localparam logic [ROW_W-1:0] Y_MAX  = {ROW_W{1'b1}};
   localparam logic [ROW_W-1:0] Y_MIN  = ROW_W'(2 * R);
   localparam logic [ROW_W-1:0] Y_OFF  = ROW_W'(R);

   if (!(win_legal(WIN) && (IMG_W >= 2 * R + 1))) begin : g_bad_cfg
      $error("census_window_stream: WIN must be odd 3..7 and IMG_W >= WIN");
   end

   logic                accept_s;
   logic                qualify_s;
   logic [XW-1:0]       x_r;
   logic [ROW_W-1:0]    y_r;
   logic [XW-1:0]       cur_x_s;
   logic [ROW_W-1:0]    cur_y_s;
   logic [PIX_W-1:0]    lb_rd_s  [WIN-1];
   logic [PIX_W-1:0]    column_s [WIN];
   logic [PIX_W-1:0]    win_r    [WIN][WIN];
   logic                win_valid_r;
   logic [XW-1:0]       win_col_r;
   logic [ROW_W-1:0]    win_row_r;
   logic [CENSUS_W-1:0] census_s;
   logic                stage_valid_s;
   logic [CENSUS_W-1:0] stage_census_s;
   logic [XW-1:0]       stage_col_s;
   logic [ROW_W-1:0]    stage_row_s;

   // A pixel arriving together with reset is dropped.
   assign accept_s = in_valid & ~rst;

   // Position of the pixel on the input this cycle; in_sof forces the frame origin.
   always_comb begin
      cur_x_s   = x_r;
      cur_y_s   = y_r;
      qualify_s = 1'b0;
      if (in_sof) begin
         cur_x_s = X_ZERO;
         cur_y_s = Y_ZERO;
      end else begin
         cur_x_s = x_r;
         cur_y_s = y_r;
      end
      qualify_s = (cur_x_s >= X_MIN) && (cur_y_s >= Y_MIN);
   end

   // x_r/y_r hold the position the next accepted pixel will take.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r <= X_ZERO;
         y_r <= Y_ZERO;
      end else if (accept_s) begin
         if (cur_x_s == X_LAST) begin
            x_r <= X_ZERO;
            y_r <= (cur_y_s == Y_MAX) ? cur_y_s : cur_y_s + Y_ONE;
         end else begin
            x_r <= cur_x_s + X_ONE;
            y_r <= cur_y_s;
         end
      end
   end

   // Buffer k holds row y-1-k; each one cascades its old entry into the next.
   for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
      logic [PIX_W-1:0] wdata_s;
      if (k == 0) begin : g_head
         assign wdata_s = in_pixel;
      end else begin : g_chain
         assign wdata_s = lb_rd_s[k-1];
      end
      census_line_buffer #(
         .PIX_W (PIX_W),
         .IMG_W (IMG_W)
      ) u_line_buffer (
         .clk   (clk),
         .we    (accept_s),
         .addr  (cur_x_s),
         .wdata (wdata_s),
         .rdata (lb_rd_s[k])
      );
   end

   // Window row 0 is the oldest line, row WIN-1 is the incoming pixel.
   for (genvar i = 0; i < WIN; i++) begin : g_col
      if (i == WIN - 1) begin : g_live
         assign column_s[i] = in_pixel;
      end else begin : g_buf
         assign column_s[i] = lb_rd_s[WIN-2-i];
      end
   end

   // Window shifts left by one column per accepted pixel; newest column on the right.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN - 1; j++) begin
               win_r[i][j] <= win_r[i][j+1];
            end
            win_r[i][WIN-1] <= column_s[i];
         end
      end
   end

   // Tag travelling alongside the window: valid pulse plus centre coordinates.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid_r <= 1'b0;
         win_col_r   <= X_ZERO;
         win_row_r   <= Y_ZERO;
      end else begin
         win_valid_r <= accept_s & qualify_s;
         if (accept_s & qualify_s) begin
            win_col_r <= cur_x_s - X_OFF;
            win_row_r <= cur_y_s - Y_OFF;
         end
      end
   end

   // Bit b maps to raster position b, or b+1 once past the centre.
   for (genvar b = 0; b < CENSUS_W; b++) begin : g_bit
      localparam int P = (b < CENTRE) ? b : b + 1;
      assign census_s[b] = (win_r[P / WIN][P % WIN] <= win_r[R][R]);
   end

`ifdef CENSUS_OUT_REG_EN
   logic                pipe_valid_r;
   logic [CENSUS_W-1:0] pipe_census_r;
   logic [XW-1:0]       pipe_col_r;
   logic [ROW_W-1:0]    pipe_row_r;

   // Retiming stage between the comparator tree and the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid_r  <= 1'b0;
         pipe_census_r <= {CENSUS_W{1'b0}};
         pipe_col_r    <= X_ZERO;
         pipe_row_r    <= Y_ZERO;
      end else begin
         pipe_valid_r <= win_valid_r;
         if (win_valid_r) begin
            pipe_census_r <= census_s;
            pipe_col_r    <= win_col_r;
            pipe_row_r    <= win_row_r;
         end
      end
   end

   assign stage_valid_s  = pipe_valid_r;
   assign stage_census_s = pipe_census_r;
   assign stage_col_s    = pipe_col_r;
   assign stage_row_s    = pipe_row_r;
`else
   assign stage_valid_s  = win_valid_r;
   assign stage_census_s = census_s;
   assign stage_col_s    = win_col_r;
   assign stage_row_s    = win_row_r;
`endif

   // Output register: data holds its last value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_census <= {CENSUS_W{1'b0}};
         out_col    <= X_ZERO;
         out_row    <= Y_ZERO;
      end else begin
         out_valid <= stage_valid_s;
         if (stage_valid_s) begin
            out_census <= stage_census_s;
            out_col    <= stage_col_s;
            out_row    <= stage_row_s;
         end
      end
   end

endmodule

// File: tb/tb_census_window_stream.sv
// Directed, table-driven bench for census_window_stream (3x3 and 5x5 instances, 8-pixel lines).
module tb_census_window_stream;

`ifdef CENSUS_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        va, sofa, ova;
   logic [10:0] pixa;
   logic [7:0]  cena;
   logic [2:0]  cola;
   logic [15:0] rowa;
   logic        vb, sofb, ovb;
   logic [10:0] pixb;
   logic [23:0] cenb;
   logic [2:0]  colb;
   logic [15:0] rowb;

   census_window_stream #(.PIX_W(11), .WIN(3), .IMG_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(va), .in_sof(sofa), .in_pixel(pixa),
      .out_valid(ova), .out_census(cena), .out_col(cola), .out_row(rowa));

   census_window_stream #(.PIX_W(11), .WIN(5), .IMG_W(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(vb), .in_sof(sofb), .in_pixel(pixb),
      .out_valid(ovb), .out_census(cenb), .out_col(colb), .out_row(rowb));

   typedef struct {
      int census;
      int col;
      int row;
      int cyc;
   } obs_t;

   typedef struct {
      bit ramp;
      int gap;
      int exp;
   } vec_t;

   obs_t mon_a[$], mon_b[$], exp_a[$], exp_b[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   bx[2];
   int   by[2];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      obs_t o;
      if (ova) begin
         o.census = int'(cena); o.col = int'(cola); o.row = int'(rowa); o.cyc = cyc;
         mon_a.push_back(o);
      end
      if (ovb) begin
         o.census = int'(cenb); o.col = int'(colb); o.row = int'(rowb); o.cyc = cyc;
         mon_b.push_back(o);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present one pixel for one cycle; the bench tracks position and queues the expected word.
   task automatic drive(input int sel, input int pix, input bit sof, input int exp);
      obs_t e;
      int   r;
      @(posedge clk); #1;
      r = (sel == 0) ? 1 : 2;
      if (sof) begin
         bx[sel] = 0;
         by[sel] = 0;
      end
      if (bx[sel] >= 2 * r && by[sel] >= 2 * r) begin
         e.census = exp; e.col = bx[sel] - r; e.row = by[sel] - r; e.cyc = cyc + LAT;
         if (sel == 0) exp_a.push_back(e);
         else          exp_b.push_back(e);
      end
      if (sel == 0) begin
         va = 1'b1; sofa = sof; pixa = 11'(pix); vb = 1'b0; sofb = 1'b0;
      end else begin
         vb = 1'b1; sofb = sof; pixb = 11'(pix); va = 1'b0; sofa = 1'b0;
      end
      bx[sel]++;
      if (bx[sel] == 8) begin
         bx[sel] = 0;
         by[sel]++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         va = 1'b0; vb = 1'b0; sofa = 1'b0; sofb = 1'b0;
      end
   endtask

   task automatic frame(input bit ramp, input int gap, input int exp);
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 8; x++) begin
            drive(0, ramp ? (x + 8 * y) : 100, (x == 0 && y == 0), exp);
            if (gap > 0) idle(gap);
         end
      end
   endtask

   task automatic check_q(input int sel, input string tag);
      obs_t m[$];
      obs_t e[$];
      int   n;
      idle(LAT + 4);
      if (sel == 0) begin
         m = mon_a; e = exp_a; mon_a.delete(); exp_a.delete();
      end else begin
         m = mon_b; e = exp_b; mon_b.delete(); exp_b.delete();
      end
      chk({tag, "_count"}, m.size(), e.size());
      n = (m.size() < e.size()) ? m.size() : e.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_census[%0d]", tag, i), m[i].census, e[i].census);
         chk($sformatf("%s_col[%0d]", tag, i), m[i].col, e[i].col);
         chk($sformatf("%s_row[%0d]", tag, i), m[i].row, e[i].row);
         chk($sformatf("%s_cycle[%0d]", tag, i), m[i].cyc, e[i].cyc);
      end
   endtask

   vec_t tbl[4];
   int   e5[4];

   initial begin
      tbl[0] = '{1'b0, 0, 'hFF};   // flat frame: ties give all ones
      tbl[1] = '{1'b1, 0, 'h0F};   // ramp: top row and left smaller
      tbl[2] = '{1'b1, 1, 'h0F};   // ramp, one idle cycle between pixels
      tbl[3] = '{1'b0, 3, 'hFF};   // flat, three idle cycles between pixels
      e5[0] = 'hFFEFFF;            // centre (2,2): bright pixel to the right, bit 12
      e5[1] = 'hFFFFFF;            // centre (3,2) is the bright pixel
      e5[2] = 'hFFF7FF;            // centre (4,2): bright pixel to the left, bit 11
      e5[3] = 'hFFFBFF;            // centre (5,2): two to the left, bit 10
      bx[0] = 0; by[0] = 0; bx[1] = 0; by[1] = 0;

      rst = 1'b1; va = 1'b0; sofa = 1'b0; pixa = 11'd0; vb = 1'b0; sofb = 1'b0; pixb = 11'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid_a", int'(ova), 0);
      chk("rst_census_a", int'(cena), 0);
      chk("rst_col_a", int'(cola), 0);
      chk("rst_row_a", int'(rowa), 0);
      chk("rst_valid_b", int'(ovb), 0);
      chk("rst_census_b", int'(cenb), 0);

      for (int i = 0; i < 4; i++) begin
         frame(tbl[i].ramp, tbl[i].gap, tbl[i].exp);
         check_q(0, $sformatf("vec%0d", i));
      end

      // Restart at what would be (3,2): the old (2,2) word still emerges, then the new frame.
      for (int i = 0; i < 19; i++) begin
         drive(0, 500, (i == 0), 'hFF);
      end
      frame(1'b1, 0, 'h0F);
      check_q(0, "sof");

      // Reset right behind a qualifying pixel; the pixel sent with reset is dropped.
      for (int i = 0; i < 19; i++) begin
         drive(0, 100, (i == 0), 'hFF);
      end
      @(posedge clk); #1;
      rst = 1'b1; va = 1'b1; sofa = 1'b0; pixa = 11'd999;
      @(posedge clk); #1;
      rst = 1'b0; va = 1'b0;
      @(negedge clk);
      chk("midrst_valid", int'(ova), 0);
      chk("midrst_census", int'(cena), 0);
      chk("midrst_col", int'(cola), 0);
      chk("midrst_row", int'(rowa), 0);
      @(posedge clk);
      mon_a.delete(); exp_a.delete();
      bx[0] = 0; by[0] = 0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 8; x++) begin
            drive(0, x + 8 * y, 1'b0, 'h0F);
         end
      end
      check_q(0, "post_rst");

      // 5x5 window, single bright pixel at (3,2) on a background of 10.
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 8; x++) begin
            drive(1, (x == 3 && y == 2) ? 2000 : 10, (x == 0 && y == 0),
                  (y == 4 && x >= 4) ? e5[x - 4] : 0);
         end
      end
      check_q(1, "win5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
